// File: rtl/hash_store_arbiter.sv
// hash_store_arbiter: round-robin share of one 32-bit output memory write port
// between two SHA256 cores. The winning digest and base address are latched on
// acceptance, then written out one word per accepted memory cycle.
//
// Handshakes: a requester holds req_valid[r] until it sees the one-cycle
// req_ready[r] pulse, then drops it; on the memory side a word moves on every
// rising edge where mem_write and mem_ready are both high, and mem_address and
// mem_data stay stable while mem_ready is low.
module hash_store_arbiter #(
   parameter int HASH_LENGTH = 8,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [1:0]                req_valid,
   input  logic [HASH_LENGTH*32-1:0] req_hash_0,
   input  logic [HASH_LENGTH*32-1:0] req_hash_1,
   input  logic [ADDR_WIDTH-1:0]     req_base_0,
   input  logic [ADDR_WIDTH-1:0]     req_base_1,
   output logic [1:0]                req_ready,
   input  logic                      mem_ready,
   output logic                      mem_write,
   output logic [ADDR_WIDTH-1:0]     mem_address,
   output logic [31:0]               mem_data,
   output logic [1:0]                done,
   output logic                      busy,
   output logic                      owner
);

   localparam int IDX_W = (HASH_LENGTH > 1) ? $clog2(HASH_LENGTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HASH_LENGTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FIN   = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic                        rr_q, rr_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [HASH_LENGTH*32-1:0]   hash_q, hash_d;
   logic                        owner_q, owner_d;
   logic [1:0]                  req_ready_q, req_ready_d;
   logic [1:0]                  done_q, done_d;
   logic                        busy_q, busy_d;
   logic                        mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [31:0]                 data_q, data_d;
   logic                        grant;
   logic [31:0]                 words [HASH_LENGTH];

   // Latched digest viewed as an array of 32-bit words; word 0 is bits 31:0.
   for (genvar w = 0; w < HASH_LENGTH; w++) begin : g_words
      assign words[w] = hash_q[w*32 +: 32];
   end

   // Grant: the lone valid requester, or the round-robin pointer when both ask.
   always_comb begin
      grant = 1'b0;
      if (req_valid == 2'b11) grant = rr_q;
      else                    grant = req_valid[1];
   end

   // Next-state and registered-output logic of the store sequencer.
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      idx_d       = idx_q;
      hash_d      = hash_q;
      owner_d     = owner_q;
      req_ready_d = 2'b00;
      done_d      = 2'b00;
      busy_d      = busy_q;
      mem_write_d = mem_write_q;
      addr_d      = addr_q;
      data_d      = data_q;
      unique case (state_q)
         ST_IDLE: begin
            mem_write_d = 1'b0;
            if (|req_valid) begin
               hash_d             = grant ? req_hash_1 : req_hash_0;
               addr_d             = grant ? req_base_1 : req_base_0;
               data_d             = grant ? req_hash_1[31:0] : req_hash_0[31:0];
               owner_d            = grant;
               idx_d              = '0;
               busy_d             = 1'b1;
               req_ready_d[grant] = 1'b1;
               mem_write_d        = 1'b1;
               state_d            = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (mem_ready) begin
               if (idx_q == LAST_IDX) begin
                  mem_write_d     = 1'b0;
                  done_d[owner_q] = 1'b1;
                  state_d         = ST_FIN;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  addr_d = addr_q + ADDR_WIDTH'(1);
                  data_d = words[idx_d];
               end
            end
         end
         ST_FIN: begin
            rr_d    = ~owner_q;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset abandons any transfer in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         rr_q        <= 1'b0;
         idx_q       <= '0;
         hash_q      <= '0;
         owner_q     <= 1'b0;
         req_ready_q <= 2'b00;
         done_q      <= 2'b00;
         busy_q      <= 1'b0;
         mem_write_q <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         idx_q       <= idx_d;
         hash_q      <= hash_d;
         owner_q     <= owner_d;
         req_ready_q <= req_ready_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         mem_write_q <= mem_write_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign owner       = owner_q;
   assign mem_write   = mem_write_q;
   assign mem_address = addr_q;
   assign mem_data    = data_q;

endmodule

// File: tb/tb_hash_store_arbiter.sv
// Directed bench for hash_store_arbiter: single store, input change after
// acceptance, backpressure, mid-transfer reset, alternating round robin and
// address wrap. Outputs are sampled on the falling clock edge.
module tb_hash_store_arbiter;

   logic         clock;
   logic         reset;
   logic [1:0]   req_valid;
   logic [255:0] req_hash_0;
   logic [255:0] req_hash_1;
   logic [15:0]  req_base_0;
   logic [15:0]  req_base_1;
   logic [1:0]   req_ready;
   logic         mem_ready;
   logic         mem_write;
   logic [15:0]  mem_address;
   logic [31:0]  mem_data;
   logic [1:0]   done;
   logic         busy;
   logic         owner;

   int checks = 0;
   int errors = 0;

   hash_store_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_hash_0  (req_hash_0),
      .req_hash_1  (req_hash_1),
      .req_base_0  (req_base_0),
      .req_base_1  (req_base_1),
      .req_ready   (req_ready),
      .mem_ready   (mem_ready),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .done        (done),
      .busy        (busy),
      .owner       (owner)
   );

   // Clock: 10 time-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] make_hash(input logic [31:0] w0);
      logic [255:0] h;
      h = '0;
      for (int i = 0; i < 8; i++) h[i*32 +: 32] = w0 + 32'(i);
      return h;
   endfunction

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " req_ready"}, 32'(req_ready), 32'h0);
      chk({tag, " mem_write"}, 32'(mem_write), 32'h0);
      chk({tag, " mem_address"}, 32'(mem_address), 32'h0);
      chk({tag, " mem_data"}, 32'(mem_data), 32'h0);
      chk({tag, " done"}, 32'(done), 32'h0);
      chk({tag, " busy"}, 32'(busy), 32'h0);
      chk({tag, " owner"}, 32'(owner), 32'h0);
   endtask

   // Called at the falling edge right after the accept edge. Checks the
   // req_ready pulse, the eight writes (optionally stalling), the done pulse
   // and the return to idle. Leaves the bench at the first idle falling edge.
   task automatic serve(input string tag, input int who, input logic [15:0] base,
                        input logic [255:0] hash, input bit scramble,
                        input int stall_idx, input int stall_len);
      logic [15:0] a;
      chk({tag, " req_ready"}, 32'(req_ready), 32'(2'b01 << who));
      chk({tag, " owner"}, 32'(owner), 32'(who));
      chk({tag, " busy"}, 32'(busy), 32'h1);
      req_valid[who] = 1'b0;
      if (scramble) begin
         if (who == 0) req_hash_0 = ~req_hash_0;
         else          req_hash_1 = ~req_hash_1;
      end
      for (int i = 0; i < 8; i++) begin
         a = base + 16'(i);
         if (i == stall_idx) begin
            mem_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               chk({tag, " stall addr"}, 32'(mem_address), 32'(a));
               chk({tag, " stall data"}, mem_data, hash[i*32 +: 32]);
               chk({tag, " stall write"}, 32'(mem_write), 32'h1);
               step();
            end
            mem_ready = 1'b1;
         end
         chk({tag, " addr"}, 32'(mem_address), 32'(a));
         chk({tag, " data"}, mem_data, hash[i*32 +: 32]);
         chk({tag, " write"}, 32'(mem_write), 32'h1);
         chk({tag, " done early"}, 32'(done), 32'h0);
         step();
      end
      chk({tag, " fin done"}, 32'(done), 32'(2'b01 << who));
      chk({tag, " fin write"}, 32'(mem_write), 32'h0);
      chk({tag, " fin busy"}, 32'(busy), 32'h1);
      step();
      chk({tag, " idle done"}, 32'(done), 32'h0);
      chk({tag, " idle busy"}, 32'(busy), 32'h0);
      chk({tag, " idle req_ready"}, 32'(req_ready), 32'h0);
   endtask

   initial begin
      logic [255:0] h0;
      logic [255:0] h1;
      reset      = 1'b0;
      req_valid  = 2'b00;
      req_hash_0 = '0;
      req_hash_1 = '0;
      req_base_0 = '0;
      req_base_1 = '0;
      mem_ready  = 1'b1;
      h0 = make_hash(32'hA000_0000);
      h1 = make_hash(32'hB000_0000);

      // Reset state.
      repeat (2) @(negedge clock);
      chk_all_zero("reset");
      reset = 1'b1;
      step();
      chk_all_zero("post reset idle");

      // Single request from 0; its input digest is inverted after acceptance.
      req_hash_0 = h0;
      req_base_0 = 16'h0010;
      req_valid  = 2'b01;
      step();
      serve("single", 0, 16'h0010, h0, 1'b1, -1, 0);

      // Backpressure: three stalled cycles at word 2.
      req_hash_0 = h0;
      req_base_0 = 16'h0200;
      req_valid  = 2'b01;
      step();
      serve("stall", 0, 16'h0200, h0, 1'b0, 2, 3);

      // Reset after the fourth write (round-robin pointer is 1 beforehand).
      req_hash_0 = h0;
      req_base_0 = 16'h0300;
      req_valid  = 2'b01;
      step();
      req_valid = 2'b00;
      repeat (4) step();
      chk("mid addr before reset", 32'(mem_address), 32'h0304);
      reset = 1'b0;
      #1;
      chk_all_zero("mid reset");
      step();
      chk("mid reset no done", 32'(done), 32'h0);
      reset = 1'b1;
      step();
      chk("after reset no done", 32'(done), 32'h0);
      chk("after reset busy", 32'(busy), 32'h0);

      // Simultaneous requests alternate, starting from requester 0.
      req_hash_0 = h0;
      req_hash_1 = h1;
      req_base_0 = 16'h0400;
      req_base_1 = 16'h0500;
      req_valid  = 2'b11;
      step();
      serve("pair1 r0", 0, 16'h0400, h0, 1'b0, -1, 0);
      step();
      serve("pair1 r1", 1, 16'h0500, h1, 1'b0, -1, 0);
      req_valid = 2'b11;
      step();
      serve("pair2 r0", 0, 16'h0400, h0, 1'b0, -1, 0);
      step();
      serve("pair2 r1", 1, 16'h0500, h1, 1'b0, -1, 0);

      // Address wrap on requester 1.
      req_hash_1 = h1;
      req_base_1 = 16'hFFFC;
      req_valid  = 2'b10;
      step();
      serve("wrap", 1, 16'hFFFC, h1, 1'b0, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
